// File: rtl/mem_port_requester_if.sv
// Bundles the request/response streams and the memory-port signals of mem_port_requester.
// master: the requester side; slave: the environment (client plus memory).
interface mem_port_requester_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_SIZE = 4
);
  logic                req_val;
  logic                req_rdy;
  logic                req_we;
  logic [IDX_SIZE-1:0] req_addr;
  logic [WIDTH-1:0]    req_wdata;

  logic                resp_val;
  logic                resp_rdy;
  logic                resp_we;
  logic [WIDTH-1:0]    resp_rdata;

  logic                mem_en;
  logic                mem_we;
  logic [IDX_SIZE-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic                mem_done;
  logic [WIDTH-1:0]    mem_rdata;

  modport master (
    input  req_val, req_we, req_addr, req_wdata, resp_rdy, mem_done, mem_rdata,
    output req_rdy, resp_val, resp_we, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_val, req_we, req_addr, req_wdata, resp_rdy, mem_done, mem_rdata,
    input  req_rdy, resp_val, resp_we, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_requester.sv
// Initiator adapter for one port of a fixed-latency memory: issues requests, tracks them,
// captures read data at the fixed latency and returns in-order responses via a credited FIFO.
module mem_port_requester #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_SIZE = 4,
  parameter int unsigned LATENCY  = 5,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_requester_if.master  bus,
  output logic                  err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OccW = $clog2(LATENCY + DEPTH + 1);

  // Tracking pipeline: index k holds stage k+1.
  logic [LATENCY-1:0]  st_val_q, st_val_d;
  logic [LATENCY-1:0]  st_we_q, st_we_d;
  logic [IDX_SIZE-1:0] st_addr_q [LATENCY];
  logic [IDX_SIZE-1:0] st_addr_d [LATENCY];

  logic [WIDTH:0]      fifo_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                err_q, err_d;
  logic                check_en_q;

  logic                req_rdy, fire, credit_ok, raw_hit, hazard;
  logic                push, pop, resp_val;
  logic [OccW-1:0]     occ;
  logic [WIDTH:0]      push_entry;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    occ = OccW'(cnt_q);
    for (int k = 0; k < int'(LATENCY); k++) begin
      occ = occ + OccW'(st_val_q[k]);
    end
  end

  // Last stage is excluded: its write has already committed by the time a read could sample.
  always_comb begin
    raw_hit = 1'b0;
    for (int k = 0; k < int'(LATENCY) - 1; k++) begin
      if (st_val_q[k] && st_we_q[k] && (st_addr_q[k] == bus.req_addr)) begin
        raw_hit = 1'b1;
      end
    end
  end

  assign credit_ok = occ < OccW'(DEPTH);
  assign hazard    = !bus.req_we && raw_hit;
  assign req_rdy   = !reset && credit_ok && !hazard;
  assign fire      = bus.req_val && req_rdy;

  assign bus.req_rdy   = req_rdy;
  assign bus.mem_en    = fire;
  assign bus.mem_we    = fire && bus.req_we;
  assign bus.mem_addr  = bus.req_addr;
  assign bus.mem_wdata = bus.req_wdata;

  always_comb begin
    st_val_d     = {st_val_q[LATENCY-2:0], fire};
    st_we_d      = {st_we_q[LATENCY-2:0], bus.req_we};
    st_addr_d[0] = bus.req_addr;
    for (int k = 1; k < int'(LATENCY); k++) begin
      st_addr_d[k] = st_addr_q[k-1];
    end
  end

  assign push       = st_val_q[LATENCY-1];
  assign push_entry = {st_we_q[LATENCY-1],
                       st_we_q[LATENCY-1] ? {WIDTH{1'b0}} : bus.mem_rdata};
  assign resp_val   = !reset && (cnt_q != '0);
  assign pop        = resp_val && bus.resp_rdy;

  assign bus.resp_val   = resp_val;
  assign bus.resp_we    = fifo_q[rd_ptr_q][WIDTH];
  assign bus.resp_rdata = fifo_q[rd_ptr_q][WIDTH-1:0];

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign err_d = err_q || (check_en_q && (bus.mem_done != st_val_q[0]));
  assign err   = err_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_val_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      check_en_q <= 1'b0;
    end else begin
      st_val_q   <= st_val_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      check_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    st_we_q   <= st_we_d;
    st_addr_q <= st_addr_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_mem_port_requester.sv
// Self-checking bench for mem_port_requester: a fixed-latency memory model, a response
// scoreboard, a table of basic transactions and directed multi-cycle corner cases.
module tb_mem_port_requester;

  localparam int unsigned L = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err;
  logic kill_done = 1'b0;

  always #5 clk = ~clk;

  mem_port_requester_if #(.WIDTH(32), .IDX_SIZE(4)) bus ();

  mem_port_requester #(
    .WIDTH(32), .IDX_SIZE(4), .LATENCY(L), .DEPTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .err  (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: done one cycle after enable, read data valid in cycle t+L,
  // writes commit at the end of cycle t+L-1.
  logic [L:1]  m_en = '0;
  logic [L:1]  m_we = '0;
  logic [3:0]  m_addr [1:L];
  logic [31:0] m_wd   [1:L];
  logic [31:0] mem_arr [16];

  always @(posedge clk) begin
    if (m_en[L-1] && m_we[L-1]) mem_arr[m_addr[L-1]] <= m_wd[L-1];
    m_en <= {m_en[L-1:1], bus.mem_en};
    m_we <= {m_we[L-1:1], bus.mem_we};
    for (int k = L; k > 1; k--) begin
      m_addr[k] <= m_addr[k-1];
      m_wd[k]   <= m_wd[k-1];
    end
    m_addr[1] <= bus.mem_addr;
    m_wd[1]   <= bus.mem_wdata;
  end

  assign bus.mem_done  = m_en[1] && !kill_done;
  assign bus.mem_rdata = (m_en[L] && !m_we[L]) ? mem_arr[m_addr[L]] : 32'h0;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          gap;
  } vec_t;

  resp_t exp_q[$];
  int    pop_cyc_q[$];
  int    fire_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: compare every popped response, and the held head while stalled.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.mem_en) fire_count++;
        if (bus.resp_val && !bus.resp_rdy && exp_q.size() != 0) begin
          check("resp_held", {bus.resp_we, bus.resp_rdata}, exp_q[0]);
        end
        if (bus.resp_val && bus.resp_rdy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: got we=%0b data=0x%0h, expected none (cycle %0d)",
                     bus.resp_we, bus.resp_rdata, cyc);
          end else begin
            e = exp_q.pop_front();
            check("resp", {bus.resp_we, bus.resp_rdata}, e);
            pop_cyc_q.push_back(cyc);
          end
        end
      end
    end
  end

  // Presents one request, waits for it to fire, records the expected response.
  task automatic issue(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp, output int fc);
    int n = 0;
    bus.req_val   = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    fc = -1;
    while (fc < 0) begin
      @(negedge clk);
      if (bus.req_rdy) begin
        fc = cyc;
        exp_q.push_back({we, exp});
      end else if (++n > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL issue_timeout: got no fire for addr %0d, expected fire", addr);
        fc = cyc;
      end
    end
    @(posedge clk);
    #1;
    bus.req_val = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl [18];
  int   fc  [18];

  initial begin
    int t0, t1, t2, f0, p0;

    tbl[0] = '{we: 1'b1, addr: 4'd3, wdata: 32'hDEADBEEF, exp: 32'h0, gap: 0};
    tbl[1] = '{we: 1'b0, addr: 4'd3, wdata: 32'h0, exp: 32'hDEADBEEF, gap: 10};
    for (int i = 0; i < 8; i++) begin
      tbl[2+i]  = '{we: 1'b1, addr: 4'(i), wdata: 32'h10 + i, exp: 32'h0, gap: (i == 0) ? 2 : 0};
      tbl[10+i] = '{we: 1'b0, addr: 4'(i), wdata: 32'h0, exp: 32'h10 + i, gap: 0};
    end

    bus.req_val   = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'd0;
    bus.req_wdata = 32'h0;
    bus.resp_rdy  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_rdy", bus.req_rdy, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_resp_val", bus.resp_val, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.req_val = 1'b0;
    @(negedge clk);
    check("post_rst_resp_val", bus.resp_val, 0);
    check("post_rst_req_rdy", bus.req_rdy, 1);
    @(posedge clk);
    #1;

    // Table: single write/read, then 8 writes and 8 back-to-back reads
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].gap > 0) begin
        repeat (tbl[i].gap) @(posedge clk);
        #1;
      end
      issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, fc[i]);
    end
    wait_drain();
    check("pop_count", pop_cyc_q.size(), 18);
    if (pop_cyc_q.size() == 18) begin
      check("read_latency", pop_cyc_q[1] - fc[1], 6);
      for (int i = 11; i < 18; i++) check("b2b_resp_spacing", pop_cyc_q[i] - pop_cyc_q[i-1], 1);
    end
    for (int i = 3; i < 18; i++) check("b2b_fire_spacing", fc[i] - fc[i-1], 1);

    // RAW hazard: same-address read stalls until the write has committed
    issue(1'b1, 4'd5, 32'hA5, 32'h0, t0);
    issue(1'b0, 4'd5, 32'h0, 32'hA5, t1);
    check("raw_stall", t1 - t0, 5);
    issue(1'b1, 4'd5, 32'hA5, 32'h0, t0);
    issue(1'b0, 4'd6, 32'h0, 32'h16, t2);
    check("raw_other_addr", t2 - t0, 1);
    wait_drain();

    // Backpressure: only DEPTH requests may be outstanding
    bus.resp_rdy = 1'b0;
    f0 = fire_count;
    p0 = pop_cyc_q.size();
    fork
      begin
        int fcx;
        for (int i = 0; i < 12; i++) begin
          issue(1'b0, 4'(i % 8), 32'h0, ((i % 8) == 5) ? 32'hA5 : 32'h10 + (i % 8), fcx);
        end
      end
      begin
        repeat (20) @(negedge clk);
        check("bp_fired", fire_count - f0, 8);
        check("bp_req_rdy", bus.req_rdy, 0);
        check("bp_resp_val", bus.resp_val, 1);
        @(posedge clk);
        #1;
        bus.resp_rdy = 1'b1;
      end
    join
    wait_drain();
    check("bp_fired_total", fire_count - f0, 12);
    check("bp_popped_total", pop_cyc_q.size() - p0, 12);

    // Reset with 2 FIFO entries held and 3 ops in flight
    bus.resp_rdy = 1'b0;
    issue(1'b0, 4'd0, 32'h0, 32'h10, t0);
    issue(1'b0, 4'd1, 32'h0, 32'h11, t0);
    repeat (8) @(posedge clk);
    #1;
    issue(1'b0, 4'd2, 32'h0, 32'h12, t0);
    issue(1'b0, 4'd3, 32'h0, 32'h13, t0);
    issue(1'b0, 4'd4, 32'h0, 32'h14, t0);
    reset = 1'b1;
    bus.req_val  = 1'b1;
    bus.req_we   = 1'b0;
    bus.req_addr = 4'd7;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_req_rdy", bus.req_rdy, 0);
    check("mid_rst_mem_en", bus.mem_en, 0);
    check("mid_rst_resp_val", bus.resp_val, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.req_val  = 1'b0;
    bus.resp_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("mid_rst_no_stale", bus.resp_val, 0);
    end
    @(posedge clk);
    #1;
    issue(1'b0, 4'd7, 32'h0, 32'h17, t0);
    wait_drain();

    // Missing done pulse sets the sticky error
    check("err_clean", err, 0);
    issue(1'b0, 4'd6, 32'h0, 32'h16, t0);
    kill_done = 1'b1;
    @(negedge clk);
    check("err_same_cycle", err, 0);
    @(posedge clk);
    #1;
    kill_done = 1'b0;
    @(negedge clk);
    check("err_set", err, 1);
    wait_drain();
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("err_in_reset", err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("err_cleared", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_requester.md
Name: mem_port_requester

Overview:
- Initiator-side adapter that drives one port of the team's fixed-latency multi-port sequential memory.
- Accepts a val/rdy request stream (read or write), issues it to the memory port, and tracks each in-flight operation.
- Captures read data at the memory's fixed latency and returns in-order responses on a val/rdy stream through a credit-controlled response FIFO.
- Blocks read-after-write hazards and checks the memory's done pulse.

Parameters:
- WIDTH, 32, data word width
- IDX_SIZE, 4, memory address width
- LATENCY, 5, cycles from issue until mem_rdata is valid; must be >= 2
- DEPTH, 8, response FIFO entries; must be >= 1, power of two

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  IDX_SIZE  request address
- req_wdata  in  WIDTH  write data
- resp_val  out  1  response valid
- resp_rdy  in  1  response ready
- resp_we  out  1  type of the operation being responded to
- resp_rdata  out  WIDTH  read data; 0 for writes
- mem_en  out  1  memory port enable
- mem_we  out  1  memory port write enable
- mem_addr  out  IDX_SIZE  memory port address
- mem_wdata  out  WIDTH  memory port write data
- mem_done  in  1  memory done; high the cycle after an enabled cycle
- mem_rdata  in  WIDTH  memory read data
- err  out  1  sticky protocol error flag

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset clears:
  - the tracking pipeline, FIFO pointers and count, and err.
  - Outputs during and after reset: req_rdy=0 while reset is high; resp_val=0, mem_en=0, err=0.
  - Memory writes already issued may still commit inside the memory; no responses are produced for them.
- Request acceptance: a request fires when req_val && req_rdy.
- mem_en = fire, combinationally. mem_we, mem_addr and mem_wdata pass req_we, req_addr and req_wdata through combinationally. When fire=0, mem_we=0.
- req_rdy = !reset && credit_ok && !hazard.
- Tracking pipeline:
  - Stages 1..LATENCY, each holding {val, we, addr}, shift every cycle.
  - Stage 1 loads {fire, req_we, req_addr}.
  - An op issued in cycle t sits in stage k during cycle t+k.
- Capture: in the cycle stage LATENCY is valid, mem_rdata holds that op's data.
  - At the end of that cycle, push {we, we ? 0 : mem_rdata} into the FIFO.
  - The earliest resp_val is therefore cycle t+LATENCY+1.
- Credit:
  - inflight = number of valid stages 1..LATENCY.
  - credit_ok = (inflight + fifo_count) < DEPTH.
  - The FIFO can never overflow; no push is ever dropped.
  - The credit check uses current-cycle values; a pop in the same cycle does not raise credit until the next cycle.
- Hazard: for a read request, hazard = 1 if any valid write in stages 1..LATENCY-1 has an address equal to req_addr.
  - Memory writes commit at the end of cycle t+LATENCY-1, so such a read would return stale data.
  - A read of the same address issued at t+LATENCY or later is allowed.
  - Write requests never see a hazard (WAW and WAR are ordered by the memory).
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap.
  - resp_val = count != 0; resp_we and resp_rdata come from the head entry.
  - Pop on resp_val && resp_rdy. A simultaneous push and pop leaves count unchanged.
  - resp_* are held stable while resp_val && !resp_rdy.
- Done check:
  - Each cycle, mem_done must equal stage-1 val. On mismatch, err is set and stays set until reset.
  - The check is suppressed in the first cycle after reset.
- Ordering: responses are returned strictly in issue order.

Test Plan:
- Read after reset: after reset, write 0xDEADBEEF to addr 3, wait 10 cycles, then read addr 3 with resp_rdy=1. Required: read fires in cycle t, resp_val in cycle t+6 with resp_we=0 and resp_rdata=0xDEADBEEF. The write response arrives earlier with resp_we=1 and resp_rdata=0.
- Back-to-back reads: write addrs 0..7 with values 0x10..0x17, then 8 consecutive reads of addrs 0..7 with resp_rdy=1. Required: one fire per cycle; responses 0x10..0x17 in order, on 8 consecutive cycles.
- RAW hazard: write 0xA5 to addr 5 in cycle t, read addr 5 presented from t+1. Required:
  - req_rdy=0 for cycles t+1..t+4; the read fires at t+5 and returns 0xA5.
  - A read of addr 6 presented at t+1 fires at once.
- Backpressure and full: DEPTH=8, resp_rdy=0, 12 read requests. Required:
  - Exactly 8 fire, then req_rdy=0.
  - After resp_rdy=1, all 8 drain in order and issue resumes.
  - No data is lost and resp_* stay stable while stalled.
- Reset mid-operation: assert reset with 3 ops in flight and 2 FIFO entries held. Required:
  - During reset: req_rdy=0 and mem_en=0.
  - After reset: resp_val=0 and no stale responses appear.
  - A new read then returns correct data.
- Done error: force mem_done=0 in the cycle after a fire. Required: err=1 from the next cycle and held until reset, which clears it.
